count_display_driver: RTL and testbench

- Downstream display stage for the countdown/timer datapath: accepts a binary count plus a load strobe, converts it to four BCD digits with a sequential double-dabble engine, and drives a multiplexed, common-anode 4-digit 7-segment display.
- Replaces the combinational binary-to-BCD + 2-digit driver pair.
- Supports 0..9999 and leading-zero blanking.

---
 rtl/count_display_driver_pkg.sv | 58 +++++
 rtl/count_display_driver_bin14_to_bcd_seq.sv | 100 ++++++++++
 rtl/count_display_driver.sv | 88 ++++++++
 tb/tb_count_display_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_display_driver_pkg.sv
// Shared constants, state encodings and helpers for the count display path.
// Holds 7-segment patterns, limits and the double-dabble nibble adjust.
package count_display_driver_pkg;

   localparam int NUM_DIGITS  = 4;
   localparam int MAX_DISPLAY = 9999;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      CONV_IDLE,
      CONV_SHIFT,
      CONV_DONE
   } conv_state_e;

   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      logic [6:0] p;
      unique case (d)
         4'd0:    p = SEG_0;
         4'd1:    p = SEG_1;
         4'd2:    p = SEG_2;
         4'd3:    p = SEG_3;
         4'd4:    p = SEG_4;
         4'd5:    p = SEG_5;
         4'd6:    p = SEG_6;
         4'd7:    p = SEG_7;
         4'd8:    p = SEG_8;
         4'd9:    p = SEG_9;
         default: p = SEG_BLANK;
      endcase
      return p;
   endfunction

   function automatic logic [13:0] clamp_value(input logic [13:0] v);
      return (v > 14'(MAX_DISPLAY)) ? 14'(MAX_DISPLAY) : v;
   endfunction

   // Add 3 to every nibble >= 5 so the following shift carries correctly.
   function automatic logic [15:0] dabble_adjust(input logic [15:0] s);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? s[i*4 +: 4] + 4'd3
                                              : s[i*4 +: 4];
      end
      return r;
   endfunction

endpackage

// File: rtl/count_display_driver_bin14_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble).
// Ports: load/value in; busy, one-cycle done with bcd[15:0] out.
module bin14_to_bcd_seq
   import count_display_driver_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [13:0] value,
   output logic        busy,
   output logic        done,
   output logic [15:0] bcd
);

   conv_state_e state_q, state_d;
   logic [13:0] bin_q, bin_d;
   logic [15:0] scr_q, scr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic [13:0] pval_q, pval_d;

   logic [15:0] adj;
   logic        start;
   logic [13:0] start_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CONV_IDLE;
         bin_q   <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         pval_q  <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         pval_q  <= pval_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CONV_IDLE:  if (load) state_d = CONV_SHIFT;
         CONV_SHIFT: if (cnt_q == 4'd0) state_d = CONV_DONE;
         CONV_DONE:  state_d = (load || pend_q) ? CONV_SHIFT : CONV_IDLE;
         default:    state_d = CONV_IDLE;
      endcase
   end

   assign adj = dabble_adjust(scr_q);

   always_comb begin
      bin_d     = bin_q;
      scr_d     = scr_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      pval_d    = pval_q;
      start     = 1'b0;
      start_val = clamp_value(value);
      unique case (state_q)
         CONV_IDLE: start = load;
         CONV_SHIFT: begin
            scr_d = (adj << 1) | {15'd0, bin_q[13]};
            bin_d = {bin_q[12:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
            if (load) begin
               pend_d = 1'b1;
               pval_d = clamp_value(value);
            end
         end
         CONV_DONE: begin
            // A load landing on DONE is newer than anything pending.
            pend_d = 1'b0;
            if (load) begin
               start = 1'b1;
            end else if (pend_q) begin
               start     = 1'b1;
               start_val = pval_q;
            end
         end
         default: ;
      endcase
      if (start) begin
         bin_d = start_val;
         scr_d = '0;
         cnt_d = 4'd13;
      end
   end

   always_comb begin
      busy = (state_q != CONV_IDLE);
      done = (state_q == CONV_DONE);
      bcd  = scr_q;
   end

endmodule

// File: rtl/count_display_driver.sv
// Multiplexed common-anode 4-digit display driver fed by a BCD converter.
// Ports: value/load in; busy, seg[6:0] (active-low), an[3:0] (active-low).
module count_display_driver
   import count_display_driver_pkg::*;
#(
   parameter int REFRESH_DIV = 100_000,
   parameter int BLANK_LZ    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] value,
   input  logic        load,
   output logic        busy,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

   logic        conv_done;
   logic [15:0] conv_bcd;

   logic [15:0]   digits_q, digits_d;
   logic [CW-1:0] scan_q, scan_d;
   logic [1:0]    idx_q, idx_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d;

   logic [NUM_DIGITS-1:0] lit;
   logic [3:0]            cur_digit;

   bin14_to_bcd_seq u_conv (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .value (value),
      .busy  (busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digits_q <= '0;
         scan_q   <= '0;
         idx_q    <= '0;
         seg_q    <= SEG_0;
         an_q     <= 4'b1110;
      end else begin
         digits_q <= digits_d;
         scan_q   <= scan_d;
         idx_q    <= idx_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
      end
   end

   // A digit stays lit once it or any higher digit is non-zero.
   always_comb begin
      lit[3] = (digits_q[15:12] != 4'd0);
      lit[2] = lit[3] | (digits_q[11:8] != 4'd0);
      lit[1] = lit[2] | (digits_q[7:4] != 4'd0);
      lit[0] = 1'b1;
      if (BLANK_LZ == 0) lit = '1;
   end

   always_comb begin
      digits_d  = conv_done ? conv_bcd : digits_q;
      scan_d    = scan_q + 1'b1;
      idx_d     = idx_q;
      if (scan_q == TC) begin
         scan_d = '0;
         idx_d  = idx_q + 2'd1;
      end
      cur_digit = digits_q[{idx_q, 2'b00} +: 4];
      seg_d     = SEG_BLANK;
      an_d      = 4'b1111;
      if (lit[idx_q]) begin
         seg_d = seg_pattern(cur_digit);
         an_d  = ~(4'b0001 << idx_q);
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver with REFRESH_DIV=4.
// Scoreboard queue of converted values feeds a per-cycle display model.
module tb_count_display_driver;

   logic        clk;
   logic        rst;
   logic [13:0] value;
   logic        load;
   logic        busy;
   logic [6:0]  seg;
   logic [3:0]  an;

   int checks   = 0;
   int failures = 0;
   bit en       = 0;

   count_display_driver #(
      .REFRESH_DIV (4),
      .BLANK_LZ    (1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .value (value),
      .load  (load),
      .busy  (busy),
      .seg   (seg),
      .an    (an)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int clampv(input int v);
      return (v > 9999) ? 9999 : v;
   endfunction

   function automatic int pw10(input int k);
      case (k)
         0:       return 1;
         1:       return 10;
         2:       return 100;
         default: return 1000;
      endcase
   endfunction

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic bit blanked(input int k, input int v);
      return (k > 0) && (v < pw10(k));
   endfunction

   function automatic logic [3:0] exp_an(input int k, input int v);
      if (blanked(k, v)) return 4'b1111;
      return ~(4'b0001 << k);
   endfunction

   function automatic logic [6:0] exp_seg(input int k, input int v);
      if (blanked(k, v)) return 7'b1111111;
      return pat((v / pw10(k)) % 10);
   endfunction

   // Scoreboard: a value is pushed when its conversion starts and
   // popped into the shown value when that conversion completes.
   int         exp_q[$];
   int         m_left, m_pval, m_disp, m_idx, m_cnt;
   bit         m_pend;
   logic [3:0] e_an;
   logic [6:0] e_seg;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left <= 0;
         m_pend <= 0;
         m_pval <= 0;
         m_disp <= 0;
         m_idx  <= 0;
         m_cnt  <= 0;
         e_an   <= 4'b1110;
         e_seg  <= 7'b1000000;
         exp_q.delete();
      end else begin
         e_an  <= exp_an(m_idx, m_disp);
         e_seg <= exp_seg(m_idx, m_disp);
         if (m_cnt == 3) begin
            m_cnt <= 0;
            m_idx <= (m_idx + 1) % 4;
         end else begin
            m_cnt <= m_cnt + 1;
         end
         if (m_left == 1) begin
            if (exp_q.size() > 0) m_disp <= exp_q.pop_front();
            m_pend <= 0;
            if (load) begin
               exp_q.push_back(clampv(int'(value)));
               m_left <= 15;
            end else if (m_pend) begin
               exp_q.push_back(m_pval);
               m_left <= 15;
            end else begin
               m_left <= 0;
            end
         end else if (m_left > 1) begin
            m_left <= m_left - 1;
            if (load) begin
               m_pend <= 1;
               m_pval <= clampv(int'(value));
            end
         end else if (load) begin
            exp_q.push_back(clampv(int'(value)));
            m_left <= 15;
         end
      end
   end

   always @(negedge clk) begin
      if (en) begin
         chk("an", an, e_an);
         chk("seg", seg, e_seg);
         chk("busy", busy, (m_left != 0));
      end
   end

   int run      = 0;
   int last_run = 0;

   always @(negedge clk) begin
      if (rst) begin
         run <= 0;
      end else if (busy) begin
         run <= run + 1;
      end else begin
         if (run != 0) last_run <= run;
         run <= 0;
      end
   end

   task automatic wait_idle();
      int i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (busy && i < 200);
      #1;
      chk("idle_timeout", busy, 0);
   endtask

   task automatic pulse(input int v, input int n);
      @(posedge clk);
      #1;
      value = 14'(v);
      load  = 1;
      repeat (n) @(posedge clk);
      #1;
      load = 0;
   endtask

   task automatic load_one(input int v, input int exp_len);
      pulse(v, 1);
      wait_idle();
      chk("busy_len", last_run, exp_len);
      repeat (20) @(posedge clk);
   endtask

   initial begin
      rst   = 1;
      load  = 0;
      value = 0;
      repeat (2) @(posedge clk);
      en = 1;
      @(negedge clk);
      rst = 0;
      repeat (16) @(posedge clk);

      load_one(1234, 15);

      pulse(99, 1);
      repeat (2) @(posedge clk);
      #1;
      value = 14'd7000;
      load  = 1;
      @(posedge clk);
      #1;
      load = 0;
      repeat (2) @(posedge clk);
      #1;
      value = 14'd42;
      load  = 1;
      @(posedge clk);
      #1;
      load = 0;
      wait_idle();
      chk("chain_len", last_run, 30);
      repeat (20) @(posedge clk);

      load_one(12000, 15);
      load_one(1005, 15);
      load_one(7, 15);
      load_one(1234, 15);

      pulse(5678, 1);
      repeat (5) @(posedge clk);
      #3;
      rst = 1;
      #1;
      chk("rst_an", an, 4'b1110);
      chk("rst_seg", seg, 7'b1000000);
      chk("rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (8) @(posedge clk);

      load_one(56, 15);

      pulse(321, 3);
      wait_idle();
      chk("hold_len", last_run, 30);
      repeat (20) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
